// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and optional write-back bypass (WB_BYPASS_EN)
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic [4:0]  read_reg_1,
  output logic [4:0]  read_reg_2,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  input  logic        flush,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [5:0]  ex_opcode,
  output logic [5:0]  ex_funct,
  output logic        ex_mem_read,
  output logic [15:0] stall_count
);

  localparam logic [5:0] OP_LW = 6'h23;

  typedef enum logic {ST_RUN, ST_BUBBLE} state_t;

  state_t      state, state_nxt;
  logic        hazard;
  logic [31:0] rs_sel, rt_sel;

  assign read_reg_1 = if_instr[25:21];
  assign read_reg_2 = if_instr[20:16];

  // Load-use detection; a bubble always has ex_valid=0, so BUBBLE never re-stalls
  always_comb begin
    hazard    = 1'b0;
    id_stall  = 1'b0;
    state_nxt = ST_RUN;
    hazard    = (state == ST_RUN) && ex_valid && ex_mem_read && (ex_rt != 5'd0) && if_valid &&
                ((ex_rt == read_reg_1) || (ex_rt == read_reg_2));
    id_stall  = hazard && !flush;
    if (hazard || flush) state_nxt = ST_BUBBLE;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

`ifndef WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write, wb_write_reg, wb_write_data};
`endif

  // Operand selection: optional same-cycle write-back forwarding, register 0 forced to zero
  always_comb begin
    rs_sel = rs_data;
    rt_sel = rt_data;
`ifdef WB_BYPASS_EN
    if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == read_reg_1)) rs_sel = wb_write_data;
    if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == read_reg_2)) rt_sel = wb_write_data;
`endif
    if (read_reg_1 == 5'd0) rs_sel = 32'd0;
    if (read_reg_2 == 5'd0) rt_sel = 32'd0;
  end

  // Pipeline register: flush or stall inserts a bubble and holds the fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= 32'd0;
      ex_rs_data  <= 32'd0;
      ex_rt_data  <= 32'd0;
      ex_imm      <= 32'd0;
      ex_rs       <= 5'd0;
      ex_rt       <= 5'd0;
      ex_rd       <= 5'd0;
      ex_opcode   <= 6'd0;
      ex_funct    <= 6'd0;
      ex_mem_read <= 1'b0;
    end else if (flush || hazard) begin
      ex_valid    <= 1'b0;
    end else begin
      ex_valid    <= if_valid;
      ex_pc       <= if_pc;
      ex_rs_data  <= rs_sel;
      ex_rt_data  <= rt_sel;
      ex_imm      <= {{16{if_instr[15]}}, if_instr[15:0]};
      ex_rs       <= if_instr[25:21];
      ex_rt       <= if_instr[20:16];
      ex_rd       <= if_instr[15:11];
      ex_opcode   <= if_instr[31:26];
      ex_funct    <= if_instr[5:0];
      ex_mem_read <= (if_instr[31:26] == OP_LW);
    end
  end

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   stall_count <= 16'd0;
    else if (id_stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard testbench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  read_reg_1, read_reg_2;
  logic [31:0] rs_data, rt_data;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        flush;
  logic        id_stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_opcode, ex_funct;
  logic        ex_mem_read;
  logic [15:0] stall_count;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2), .rs_data(rs_data), .rt_data(rt_data),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_mem_read(ex_mem_read), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADDI  = 32'h2128FFFC;
  localparam logic [31:0] I_LW8   = 32'h8D280000;
  localparam logic [31:0] I_ADD   = 32'h01095020;
  localparam logic [31:0] I_LW0   = 32'h8D200000;
  localparam logic [31:0] I_ADD00 = 32'h00005020;
`ifdef WB_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'hDEADBEEF;
`else
  localparam logic [31:0] BYP_EXP = 32'h00000000;
`endif

  typedef struct {
    logic        v;
    logic        fc;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  op, fn;
    logic        mr;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic v, input logic fc, input logic [31:0] pc, input logic [31:0] rsd,
                              input logic [31:0] rtd, input logic [31:0] imm, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] op,
                              input logic [5:0] fn, input logic mr, input logic [15:0] cnt);
    exp_t e;
    e.v = v; e.fc = fc; e.pc = pc; e.rsd = rsd; e.rtd = rtd; e.imm = imm;
    e.rs = rs; e.rt = rt; e.rd = rd; e.op = op; e.fn = fn; e.mr = mr; e.cnt = cnt;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic fl, input logic wbw, input logic [4:0] wbr,
                       input logic [31:0] wbd, input logic exp_stall);
    @(negedge clk);
    rst_n = 1'b1; if_valid = v; if_instr = instr; if_pc = pc; rs_data = rsd; rt_data = rtd;
    flush = fl; wb_reg_write = wbw; wb_write_reg = wbr; wb_write_data = wbd;
    #1 chk("id_stall", 32'(id_stall), 32'(exp_stall));
  endtask

  // Monitor: one expected entry per captured cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_valid", 32'(ex_valid), 32'(e.v));
        chk("stall_count", 32'(stall_count), 32'(e.cnt));
        if (e.fc) begin
          chk("ex_pc", ex_pc, e.pc);
          chk("ex_rs_data", ex_rs_data, e.rsd);
          chk("ex_rt_data", ex_rt_data, e.rtd);
          chk("ex_imm", ex_imm, e.imm);
          chk("ex_rs", 32'(ex_rs), 32'(e.rs));
          chk("ex_rt", 32'(ex_rt), 32'(e.rt));
          chk("ex_rd", 32'(ex_rd), 32'(e.rd));
          chk("ex_opcode", 32'(ex_opcode), 32'(e.op));
          chk("ex_funct", 32'(ex_funct), 32'(e.fn));
          chk("ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [16:0] c;
    rst_n = 1'b0; if_valid = 1'b1; if_instr = I_ADDI; if_pc = 32'h100; rs_data = 32'd5; rt_data = 32'd7;
    flush = 1'b0; wb_reg_write = 1'b0; wb_write_reg = 5'd0; wb_write_data = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);
    chk("rst_id_stall", 32'(id_stall), 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_ex_mem_read", 32'(ex_mem_read), 32'd0);

    drive(1, I_ADDI, 32'h100, 32'd5, 32'd7, 0, 0, 5'd0, 32'd0, 0);
    q.push_back(mk(1, 1, 32'h100, 32'd5, 32'd7, 32'hFFFFFFFC, 5'd9, 5'd8, 5'd31, 6'h08, 6'h3C, 0, 16'd0));
    drive(1, I_LW8, 32'h104, 32'h1000, 32'h55, 0, 0, 5'd0, 32'd0, 0);
    q.push_back(mk(1, 1, 32'h104, 32'h1000, 32'h55, 32'd0, 5'd9, 5'd8, 5'd0, 6'h23, 6'h00, 1, 16'd0));
    drive(1, I_ADD, 32'h108, 32'h11, 32'h22, 0, 0, 5'd0, 32'd0, 1);
    q.push_back(mk(0, 1, 32'h104, 32'h1000, 32'h55, 32'd0, 5'd9, 5'd8, 5'd0, 6'h23, 6'h00, 1, 16'd1));
    drive(1, I_ADD, 32'h108, 32'h11, 32'h22, 0, 0, 5'd0, 32'd0, 0);
    q.push_back(mk(1, 1, 32'h108, 32'h11, 32'h22, 32'h5020, 5'd8, 5'd9, 5'd10, 6'h00, 6'h20, 0, 16'd1));
    drive(1, I_LW8, 32'h10C, 32'h1000, 32'h55, 0, 0, 5'd0, 32'd0, 0);
    q.push_back(mk(1, 1, 32'h10C, 32'h1000, 32'h55, 32'd0, 5'd9, 5'd8, 5'd0, 6'h23, 6'h00, 1, 16'd1));
    drive(1, I_ADD, 32'h110, 32'h11, 32'h22, 1, 0, 5'd0, 32'd0, 0);
    q.push_back(mk(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 6'h00, 6'h00, 0, 16'd1));
    drive(1, I_LW0, 32'h114, 32'h1000, 32'h55, 0, 0, 5'd0, 32'd0, 0);
    q.push_back(mk(1, 1, 32'h114, 32'h1000, 32'h0, 32'd0, 5'd9, 5'd0, 5'd0, 6'h23, 6'h00, 1, 16'd1));
    drive(1, I_ADD00, 32'h118, 32'h33, 32'h44, 0, 0, 5'd0, 32'd0, 0);
    q.push_back(mk(1, 1, 32'h118, 32'h0, 32'h0, 32'h5020, 5'd0, 5'd0, 5'd10, 6'h00, 6'h20, 0, 16'd1));
    drive(1, I_ADD, 32'h11C, 32'h0, 32'h22, 0, 1, 5'd8, 32'hDEADBEEF, 0);
    q.push_back(mk(1, 1, 32'h11C, BYP_EXP, 32'h22, 32'h5020, 5'd8, 5'd9, 5'd10, 6'h00, 6'h20, 0, 16'd1));
    drive(1, I_ADD00, 32'h120, 32'h0, 32'h0, 0, 1, 5'd0, 32'hDEADBEEF, 0);
    q.push_back(mk(1, 1, 32'h120, 32'h0, 32'h0, 32'h5020, 5'd0, 5'd0, 5'd10, 6'h00, 6'h20, 0, 16'd1));
    drive(0, I_ADDI, 32'h124, 32'd5, 32'd7, 0, 0, 5'd0, 32'd0, 0);
    q.push_back(mk(0, 1, 32'h124, 32'd5, 32'd7, 32'hFFFFFFFC, 5'd9, 5'd8, 5'd31, 6'h08, 6'h3C, 0, 16'd1));
    drive(1, I_LW8, 32'h128, 32'h1000, 32'h55, 0, 0, 5'd0, 32'd0, 0);
    q.push_back(mk(1, 1, 32'h128, 32'h1000, 32'h55, 32'd0, 5'd9, 5'd8, 5'd0, 6'h23, 6'h00, 1, 16'd1));

    drive(1, I_ADD, 32'h12C, 32'h11, 32'h22, 0, 0, 5'd0, 32'd0, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_id_stall", 32'(id_stall), 32'd0);
    chk("midrst_ex_valid", 32'(ex_valid), 32'd0);
    chk("midrst_stall_count", 32'(stall_count), 32'd0);
    drive(1, I_ADD, 32'h12C, 32'h11, 32'h22, 0, 0, 5'd0, 32'd0, 0);
    q.push_back(mk(1, 1, 32'h12C, 32'h11, 32'h22, 32'h5020, 5'd8, 5'd9, 5'd10, 6'h00, 6'h20, 0, 16'd0));

    @(negedge clk);
    force dut.stall_count = 16'hFFFD;
    #1 release dut.stall_count;
    c = 17'h0FFFD;
    for (int i = 0; i < 3; i++) begin
      drive(1, I_LW8, 32'h200 + 32'(8 * i), 32'h1000, 32'h55, 0, 0, 5'd0, 32'd0, 0);
      q.push_back(mk(1, 1, 32'h200 + 32'(8 * i), 32'h1000, 32'h55, 32'd0, 5'd9, 5'd8, 5'd0, 6'h23, 6'h00, 1, c[15:0]));
      drive(1, I_ADD, 32'h204 + 32'(8 * i), 32'h11, 32'h22, 0, 0, 5'd0, 32'd0, 1);
      if (c < 17'h0FFFF) c = c + 17'd1;
      q.push_back(mk(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 6'h00, 6'h00, 0, c[15:0]));
    end
    drive(1, I_LW8, 32'h220, 32'h1000, 32'h55, 0, 0, 5'd0, 32'd0, 0);
    q.push_back(mk(1, 1, 32'h220, 32'h1000, 32'h55, 32'd0, 5'd9, 5'd8, 5'd0, 6'h23, 6'h00, 1, 16'hFFFF));

    repeat (3) @(posedge clk);
    #2;
    total_cnt++;
    if (q.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
